// File: rtl/ovi_vpu_model_pkg.sv
// ovi_vpu_model_pkg
// Shared OVI bus widths, bus structs and small helpers for the vector-unit
// stand-in model. Imported by ovi_vpu_model and its testbench.
//   core_issue_bus     : instr, vl, sew, valid  (core -> vector unit)
//   core_completed_bus : valid, illegal, dest_reg (vector unit -> core)
//   issue_entry_t      : what the issue buffer stores per instruction
package ovi_vpu_model_pkg;

  localparam int OVI_INSTR_WIDTH = 32;
  localparam int OVI_VL_WIDTH    = 8;
  localparam int OVI_SEW_WIDTH   = 2;
  localparam int OVI_DEST_WIDTH  = 5;

  typedef struct packed {
    logic [OVI_INSTR_WIDTH-1:0] instr;
    logic [OVI_VL_WIDTH-1:0]    vl;
    logic [OVI_SEW_WIDTH-1:0]   sew;
    logic                       valid;
  } core_issue_bus;

  typedef struct packed {
    logic                      valid;
    logic                      illegal;
    logic [OVI_DEST_WIDTH-1:0] dest_reg;
  } core_completed_bus;

  typedef struct packed {
    logic [OVI_INSTR_WIDTH-1:0] instr;
    logic [OVI_VL_WIDTH-1:0]    vl;
    logic [OVI_SEW_WIDTH-1:0]   sew;
  } issue_entry_t;

  // sew encoding 3 is reserved, and an empty vector has nothing to execute.
  function automatic logic is_illegal(input logic [OVI_VL_WIDTH-1:0]  vl,
                                      input logic [OVI_SEW_WIDTH-1:0] sew);
    return (sew == OVI_SEW_WIDTH'(3)) || (vl == '0);
  endfunction

endpackage

// File: rtl/ovi_vpu_model_issue_fifo.sv
// ovi_issue_fifo
// In-order issue buffer with synchronous push/pop. A push while full is
// refused even if a pop happens in the same cycle.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   push       : request to store push_data
//   push_data  : entry to store
//   pop        : remove head entry (ignored when empty)
//   pop_data   : current head entry (combinational from storage)
//   count      : number of stored entries, log2(DEPTH)+1 bits
//   full/empty : count == DEPTH / count == 0
module ovi_issue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only valid entries (tracked by count) are read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ovi_vpu_model.sv
// ovi_vpu_model
// Vector-unit side of the OVI handshake: buffers issued instructions,
// models execution latency from vl, returns one completion per instruction.
//   CLK, RST       : clock, synchronous active-high reset
//   CORE_ISSUE     : issue bus from the core (instr, vl, sew, valid)
//   CORE_HALT      : backpressure, high while the buffer is full
//   CORE_COMPLETED : registered completion pulse (valid, illegal, dest_reg)
//   BUSY           : buffer non-empty or an instruction in flight
//   OVERFLOW       : sticky, an issue arrived while the buffer was full
module ovi_vpu_model
  import ovi_vpu_model_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LAT_BASE = 2,
  parameter int LANES    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  core_issue_bus     CORE_ISSUE,
  output logic              CORE_HALT,
  output core_completed_bus CORE_COMPLETED,
  output logic              BUSY,
  output logic              OVERFLOW
);

  typedef enum logic [1:0] {IDLE, EXEC, RESPOND} exec_state_e;

  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W    = $bits(issue_entry_t);
  localparam int LANE_SHIFT = $clog2(LANES);
  localparam int SUM_W      = OVI_VL_WIDTH + 1;
  localparam int LAT_W      = SUM_W + $clog2(LAT_BASE + 1) + 1;

  issue_entry_t              push_entry;
  issue_entry_t              head;
  logic [ENTRY_W-1:0]        head_bits;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;

  exec_state_e               state_q, state_d;
  logic [LAT_W-1:0]          cnt_q, cnt_d;
  logic                      exec_illegal_q;
  logic [OVI_DEST_WIDTH-1:0] exec_dest_q;
  core_completed_bus         completed_d;

  logic                      head_illegal;
  logic [OVI_DEST_WIDTH-1:0] head_dest;
  logic [SUM_W-1:0]          vl_sum;
  logic [LAT_W-1:0]          lat;
  logic                      unused_head_bits;

  assign push_entry = '{instr: CORE_ISSUE.instr, vl: CORE_ISSUE.vl, sew: CORE_ISSUE.sew};

  ovi_issue_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_issue_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (CORE_ISSUE.valid),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head         = issue_entry_t'(head_bits);
  assign head_illegal = is_illegal(head.vl, head.sew);
  assign head_dest    = head.instr[11:7];
  assign unused_head_bits = ^{head.instr[OVI_INSTR_WIDTH-1:12], head.instr[6:0]};

  // ceil(vl/LANES) computed one bit wider than vl so vl near max cannot wrap.
  assign vl_sum = {1'b0, head.vl} + SUM_W'(LANES - 1);
  assign lat    = LAT_W'(LAT_BASE) + LAT_W'(vl_sum >> LANE_SHIFT);

  // HALT depends only on the registered count, never on the incoming issue.
  assign CORE_HALT = fifo_full;
  assign BUSY      = (fifo_count != '0) || (state_q != IDLE);

  // Next-state logic. The completion register is loaded on the edge that
  // enters RESPOND, so valid is high exactly while the FSM sits in RESPOND.
  // An illegal entry goes straight from IDLE to RESPOND, so its flag and
  // dest come from the buffer head rather than the exec registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    completed_d = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_illegal) begin
            state_d = RESPOND;
          end else begin
            state_d = EXEC;
            cnt_d   = lat - 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = RESPOND;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == RESPOND) begin
      completed_d.valid    = 1'b1;
      completed_d.illegal  = (state_q == IDLE) ? head_illegal : exec_illegal_q;
      completed_d.dest_reg = (state_q == IDLE) ? head_dest : exec_dest_q;
    end
  end

  // State, exec registers and registered completion outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      exec_illegal_q <= 1'b0;
      exec_dest_q    <= '0;
      CORE_COMPLETED <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      CORE_COMPLETED <= completed_d;
      if (pop) begin
        exec_illegal_q <= head_illegal;
        exec_dest_q    <= head_dest;
      end
    end
  end

  // A dropped issue is remembered until reset.
  always_ff @(posedge CLK) begin
    if (RST)                                 OVERFLOW <= 1'b0;
    else if (CORE_ISSUE.valid && fifo_full)  OVERFLOW <= 1'b1;
  end

endmodule

// File: tb/tb_ovi_vpu_model.sv
// tb_ovi_vpu_model
// Self-checking bench for ovi_vpu_model. Drives directed and random issue
// traffic and compares every cycle against an edge-based reference model:
// the unit is free to take a new instruction two edges after its previous
// completion, finishes a legal one LAT_BASE + ceil(vl/LANES) edges after
// taking it, and an illegal one on the taking edge itself.
module tb_ovi_vpu_model;
  import ovi_vpu_model_pkg::*;

  localparam int DEPTH    = 4;
  localparam int LAT_BASE = 2;
  localparam int LANES    = 4;

  logic              CLK;
  logic              RST;
  core_issue_bus     CORE_ISSUE;
  logic              CORE_HALT;
  core_completed_bus CORE_COMPLETED;
  logic              BUSY;
  logic              OVERFLOW;

  ovi_vpu_model #(
    .DEPTH    (DEPTH),
    .LAT_BASE (LAT_BASE),
    .LANES    (LANES)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .CORE_ISSUE     (CORE_ISSUE),
    .CORE_HALT      (CORE_HALT),
    .CORE_COMPLETED (CORE_COMPLETED),
    .BUSY           (BUSY),
    .OVERFLOW       (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    int          vl;
    int          sew;
  } model_ent_t;

  typedef struct {
    int          at_edge;
    bit          illegal;
    logic [4:0]  dest;
  } model_cmp_t;

  model_ent_t pending[$];
  model_cmp_t exp_q[$];
  int         edge_no    = 0;
  int         free_edge  = 0;
  bit         active     = 0;
  int         active_resp = 0;
  bit         model_ovf  = 0;
  int         vectors    = 0;
  int         miscompares = 0;

  // Advance the reference model across one rising edge.
  task automatic model_edge(input bit rst, input bit v, input logic [31:0] instr,
                            input int vl, input int sew);
    bit full;
    model_ent_t e;
    model_cmp_t c;
    int lat;
    edge_no++;
    if (rst) begin
      pending.delete();
      exp_q.delete();
      active    = 0;
      free_edge = 0;
      model_ovf = 0;
      return;
    end
    full = (pending.size() == DEPTH);
    if (pending.size() > 0 && edge_no >= free_edge) begin
      e = pending.pop_front();
      c.illegal = (e.sew == 3) || (e.vl == 0);
      c.dest    = e.instr[11:7];
      lat       = LAT_BASE + (e.vl + LANES - 1) / LANES;
      c.at_edge = c.illegal ? edge_no : edge_no + lat;
      exp_q.push_back(c);
      active      = 1;
      active_resp = c.at_edge;
      free_edge   = c.at_edge + 2;
    end
    if (v) begin
      if (!full) begin
        e.instr = instr; e.vl = vl; e.sew = sew;
        pending.push_back(e);
      end else begin
        model_ovf = 1;
      end
    end
  endtask

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s edge=%0d observed=0x%0h expected=0x%0h", tag, edge_no, obs, expv);
    end
  endtask

  task automatic check_output();
    bit         ev;
    bit         ei;
    logic [4:0] ed;
    ev = (exp_q.size() > 0) && (exp_q[0].at_edge == edge_no);
    ei = 0;
    ed = '0;
    if (ev) begin
      ei = exp_q[0].illegal;
      ed = exp_q[0].dest;
      exp_q.delete(0);
    end
    compare("completed_valid",   32'(CORE_COMPLETED.valid),    32'(ev));
    compare("completed_illegal", 32'(CORE_COMPLETED.illegal),  32'(ei));
    compare("completed_dest",    32'(CORE_COMPLETED.dest_reg), 32'(ed));
    compare("halt",     32'(CORE_HALT), 32'(pending.size() == DEPTH));
    compare("busy",     32'(BUSY),      32'(pending.size() > 0 || (active && edge_no <= active_resp)));
    compare("overflow", 32'(OVERFLOW),  32'(model_ovf));
  endtask

  task automatic apply_stimulus(input bit rst, input bit v, input logic [31:0] instr,
                                input int vl, input int sew);
    RST              = rst;
    CORE_ISSUE.valid = v;
    CORE_ISSUE.instr = instr;
    CORE_ISSUE.vl    = 8'(vl);
    CORE_ISSUE.sew   = 2'(sew);
    @(posedge CLK);
    model_edge(rst, v, instr, vl, sew);
    #1;
    check_output();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, $urandom(), 0, 0);
  endtask

  // Well-behaved issuer: only drives valid when the buffer has room.
  task automatic issue_if_room(input logic [31:0] instr, input int vl, input int sew);
    apply_stimulus(0, pending.size() < DEPTH, instr, vl, sew);
  endtask

  initial begin
    int sweep_vl[4];
    sweep_vl = '{1, 4, 5, 17};
    RST        = 1'b1;
    CORE_ISSUE = '0;

    $display("[TB] reset");
    apply_stimulus(1, 0, 32'h0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0);
    idle(2);

    $display("[TB] single legal issue");
    apply_stimulus(0, 1, 32'h0220_8157, 8, 2);
    idle(10);

    $display("[TB] illegal issues");
    apply_stimulus(0, 1, $urandom(), 8, 3);
    idle(4);
    apply_stimulus(0, 1, $urandom(), 0, 0);
    idle(4);

    $display("[TB] fill with backpressure");
    for (int i = 0; i < 10; i++) issue_if_room($urandom(), 16, 2);
    idle(70);

    $display("[TB] forced overflow");
    for (int i = 0; i < 12; i++) apply_stimulus(0, 1, $urandom(), 16, $urandom_range(0, 2));
    idle(80);

    $display("[TB] reset mid-exec");
    for (int i = 0; i < 4; i++) issue_if_room($urandom(), 16, 1);
    apply_stimulus(1, 0, 32'h0, 0, 0);
    idle(10);
    apply_stimulus(0, 1, $urandom(), 8, 0);
    idle(12);

    $display("[TB] latency sweep");
    foreach (sweep_vl[i]) begin
      apply_stimulus(0, 1, $urandom(), sweep_vl[i], $urandom_range(0, 2));
      idle(12);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 150; i++)
      issue_if_room($urandom(), $urandom_range(0, 40), $urandom_range(0, 3));
    idle(120);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
